// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell.
// Operands are shifted out LSB first; the carry is kept in a flop between bits.
module serial_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_y,
    input  logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic [WIDTH-2:0] res_sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_next = {fa_y, res_sh_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state_q == RUN) begin
            fa_a   = a_sh_q[0];
            fa_b   = b_sh_q[0];
            fa_cin = carry_q;
        end
    end

    // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= op_a;
                        b_sh_q  <= op_b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    res_sh_q <= res_next[WIDTH-1:1];
                    carry_q  <= fa_c;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        sum_q  <= res_next;
                        cout_q <= fa_c;
                        // Carry into the MSB differing from carry out of it flags signed overflow.
                        ovf_q  <= carry_q ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: models the adder cell and checks results against
// plain integer arithmetic for add/subtract, carry and signed overflow.
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         fa_a, fa_b, fa_cin, fa_y, fa_c;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    // Observations captured by run_op
    int           lat;
    logic [W-1:0] obs_fa_a, obs_fa_b, obs_fa_cin;
    logic [W-1:0] obs_sum;
    logic         obs_cout, obs_ovf, obs_busy_done;
    logic         obs_done_after, obs_busy_after, obs_held_ok;
    logic [2:0]   obs_idle_fa;

    always #5 clk = ~clk;

    assign fa_y = fa_a ^ fa_b ^ fa_cin;
    assign fa_c = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_y(fa_y), .fa_c(fa_c),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Returns {ovf, cout, sum} from integer arithmetic.
    function automatic logic [W+1:0] model(input int a, input int b, input bit s);
        int mask, bb, t, sa, sb, r;
        logic o;
        logic [W+1:0] res;
        mask = (1 << W) - 1;
        bb = s ? ((~b) & mask) : b;
        t  = a + bb + (s ? 1 : 0);
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        r  = s ? sa - sb : sa + sb;
        o  = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        res[W-1:0] = W'(t & mask);
        res[W]     = ((t >> W) & 1) != 0;
        res[W+1]   = o;
        return res;
    endfunction

    // Carry into each bit position of a + b' + s.
    function automatic logic [W-1:0] model_cin(input int a, input int b, input bit s);
        int mask, bb, lo;
        logic [W-1:0] v;
        mask = (1 << W) - 1;
        bb = s ? ((~b) & mask) : b;
        for (int i = 0; i < W; i++) begin
            lo = (1 << i) - 1;
            v[i] = ((((a & lo) + (bb & lo) + (s ? 1 : 0)) >> i) & 1) != 0;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] prev_sum;
        wait_idle();
        op_a = a; op_b = b; sub = s; start = 1'b1;
        prev_sum = sum;
        step();
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        lat = 1;
        obs_fa_a = '0; obs_fa_b = '0; obs_fa_cin = '0;
        obs_held_ok = 1'b1;
        while (!done && lat < 20) begin
            if (lat <= W) begin
                obs_fa_a[lat-1]   = fa_a;
                obs_fa_b[lat-1]   = fa_b;
                obs_fa_cin[lat-1] = fa_cin;
            end
            if (sum !== prev_sum || !busy) obs_held_ok = 1'b0;
            step();
            lat++;
        end
        if (!done) lat = -1;
        obs_sum = sum; obs_cout = cout; obs_ovf = ovf; obs_busy_done = busy;
        step();
        obs_done_after = done;
        obs_busy_after = busy;
        obs_idle_fa = {fa_a, fa_b, fa_cin};
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%0d cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
        end
        step();
        reset = 1'b0;
        step();
        run_op(4'd7, 4'd8, 1'b0);
        checks++;
        if (obs_sum !== 4'd15) begin
            errors++;
            $display("FAIL pre_reset_sum: got %0d want 15", obs_sum);
        end
        op_a = 4'd3; op_b = 4'd4; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%0d cout=%b ovf=%b fa=%b%b%b, want all 0",
                     busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin);
        end
        step();
        reset = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 10; i++) begin
                if (done || busy) bad++;
                step();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL post_reset_idle: %0d cycles with busy/done high, want 0", bad);
            end
        end
        run_op(4'd2, 4'd3, 1'b0);
        checks++;
        if (obs_sum !== 4'd5 || lat != W + 1) begin
            errors++;
            $display("FAIL after_reset_op: sum=%0d lat=%0d, want sum=5 lat=%0d", obs_sum, lat, W + 1);
        end
    endtask

    task automatic test_add();
        run_op(4'd7, 4'd9, 1'b0);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL add79_latency: got %0d want 5", lat);
        end
        checks++;
        if ({obs_sum, obs_cout, obs_ovf} !== {4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add79_result: sum=%0d cout=%b ovf=%b want sum=0 cout=1 ovf=0", obs_sum, obs_cout, obs_ovf);
        end
        checks++;
        if (obs_fa_a !== 4'b0111 || obs_fa_cin !== 4'b1110) begin
            errors++;
            $display("FAIL add79_bitseq: fa_a=%b fa_cin=%b want fa_a=0111 fa_cin=1110 (bit0 first at right)", obs_fa_a, obs_fa_cin);
        end
        checks++;
        if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0 || obs_idle_fa !== 3'b000) begin
            errors++;
            $display("FAIL add79_after: done=%b busy=%b fa=%b want 0 0 000", obs_done_after, obs_busy_after, obs_idle_fa);
        end
        run_op(4'd5, 4'd4, 1'b0);
        checks++;
        if ({obs_sum, obs_cout, obs_ovf} !== {4'd9, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add54_result: sum=%0d cout=%b ovf=%b want sum=9 cout=0 ovf=1", obs_sum, obs_cout, obs_ovf);
        end
    endtask

    task automatic test_sub();
        run_op(4'd3, 4'd5, 1'b1);
        checks++;
        if ({obs_sum, obs_cout, obs_ovf} !== {4'd14, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub35_result: sum=%0d cout=%b ovf=%b want sum=14 cout=0 ovf=0", obs_sum, obs_cout, obs_ovf);
        end
        checks++;
        if (obs_fa_cin[0] !== 1'b1 || obs_fa_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL sub35_first_bit: fa_cin=%b fa_b=%b want fa_cin=1 fa_b=0", obs_fa_cin[0], obs_fa_b[0]);
        end
        run_op(4'd8, 4'd1, 1'b1);
        checks++;
        if ({obs_sum, obs_cout, obs_ovf} !== {4'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub81_result: sum=%0d cout=%b ovf=%b want sum=7 cout=1 ovf=1", obs_sum, obs_cout, obs_ovf);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         s;
        logic [W+1:0] exp;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            exp = model(int'(a), int'(b), s);
            run_op(a, b, s);
            checks++;
            if ({obs_ovf, obs_cout, obs_sum} !== exp || lat != W + 1) begin
                errors++;
                $display("FAIL rand_result: a=%0d b=%0d sub=%b got ovf=%b cout=%b sum=%0d lat=%0d want ovf=%b cout=%b sum=%0d lat=%0d",
                         a, b, s, obs_ovf, obs_cout, obs_sum, lat, exp[W+1], exp[W], exp[W-1:0], W + 1);
            end
            checks++;
            if (obs_fa_a !== a || obs_fa_b !== (b ^ {W{s}}) || obs_fa_cin !== model_cin(int'(a), int'(b), s)) begin
                errors++;
                $display("FAIL rand_bitseq: a=%0d b=%0d sub=%b fa_a=%b fa_b=%b fa_cin=%b want %b %b %b",
                         a, b, s, obs_fa_a, obs_fa_b, obs_fa_cin, a, b ^ {W{s}}, model_cin(int'(a), int'(b), s));
            end
            checks++;
            if (!obs_held_ok || obs_busy_done !== 1'b1 || obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_control: held_ok=%b busy_in_done=%b done_after=%b busy_after=%b want 1 1 0 0",
                         obs_held_ok, obs_busy_done, obs_done_after, obs_busy_after);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int NC = 36;
        logic [W-1:0] ra [NC];
        logic [W-1:0] rb [NC];
        logic         rs [NC];
        logic [W+1:0] exp;
        int bad_ctrl = 0;
        int ops = 0;
        wait_idle();
        for (int c = 0; c < NC; c++) begin
            ra[c] = W'($urandom); rb[c] = W'($urandom); rs[c] = 1'($urandom);
            op_a = ra[c]; op_b = rb[c]; sub = rs[c]; start = 1'b1;
            if (busy !== ((c % (W + 2)) != 0) || done !== ((c % (W + 2)) == W + 1)) begin
                bad_ctrl++;
                $display("FAIL b2b_ctrl: cycle %0d busy=%b done=%b want busy=%b done=%b",
                         c, busy, done, (c % (W + 2)) != 0, (c % (W + 2)) == W + 1);
            end
            if ((c % (W + 2)) == W + 1) begin
                exp = model(int'(ra[c-W-1]), int'(rb[c-W-1]), rs[c-W-1]);
                ops++;
                checks++;
                if ({ovf, cout, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result: op %0d got ovf=%b cout=%b sum=%0d want ovf=%b cout=%b sum=%0d",
                             ops, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
                end
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (bad_ctrl != 0) errors++;
        checks++;
        if (ops != NC / (W + 2)) begin
            errors++;
            $display("FAIL b2b_count: %0d results seen want %0d", ops, NC / (W + 2));
        end
        wait_idle();
    endtask

    initial begin
        #2;
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
